// File: rtl/lite16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lite16_pkg
// Description : Shared widths and word/address types for the LITE-16 core.
// Revision    : 1.0 - initial release
// ============================================================================

package lite16_pkg;

  localparam int LITE16_DATA_W     = 16;
  localparam int LITE16_REG_ADDR_W = 3;
  localparam int LITE16_NUM_REGS   = 8;

  typedef logic [LITE16_DATA_W-1:0]     word_t;
  typedef logic [LITE16_REG_ADDR_W-1:0] reg_addr_t;

endpackage : lite16_pkg

`default_nettype wire

// File: rtl/lite16_rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : lite16_rf_read_port
// Description : One registered register-file read port: address mux, R0
//               masking, same-cycle write bypass and output register.
//               Optional feature macro: LITE16_RF_BYPASS_EN (write-first).
// Revision    : 1.0 - initial release
// ============================================================================

module lite16_rf_read_port
  import lite16_pkg::*;
#(
  parameter int DATA_W   = LITE16_DATA_W,
  parameter int NUM_REGS = LITE16_NUM_REGS,
  parameter int ADDR_W   = LITE16_REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] mem_i [NUM_REGS],
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

`ifdef LITE16_RF_BYPASS_EN
  localparam bit c_BYPASS = 1'b1;
`else
  localparam bit c_BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              w_zero_hit;
  logic              w_bypass_hit;

  // R0 masking is checked first so a dropped R0 write can never be bypassed.
  assign w_zero_hit   = (ZERO_REG != 0) && (raddr_i == '0);
  assign w_bypass_hit = c_BYPASS && we_i && (waddr_i == raddr_i);

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      if (w_zero_hit) begin
        rdata_d = '0;
      end else if (w_bypass_hit) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_i[raddr_i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : lite16_rf_read_port

`default_nettype wire

// File: rtl/lite16_regfile.sv
`default_nettype none
// ============================================================================
// Module      : lite16_regfile
// Description : LITE-16 architectural register file, one write port and two
//               registered read ports (1-cycle latency).
//               Optional feature macro: LITE16_RF_BYPASS_EN (write-first).
// Revision    : 1.0 - initial release
// ============================================================================

module lite16_regfile
  import lite16_pkg::*;
#(
  parameter int DATA_W   = LITE16_DATA_W,
  parameter int NUM_REGS = LITE16_NUM_REGS,
  parameter int ADDR_W   = LITE16_REG_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              w_wr_ok;

  // Writes to R0 are dropped when it is hardwired, so it stays at its reset 0.
  assign w_wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  lite16_rf_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .re_i    (re_a),
    .raddr_i (raddr_a),
    .mem_i   (mem_q),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rdata_o (rdata_a)
  );

  lite16_rf_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .re_i    (re_b),
    .raddr_i (raddr_b),
    .mem_i   (mem_q),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .rdata_o (rdata_b)
  );

endmodule : lite16_regfile

`default_nettype wire

// File: tb/tb_lite16_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_lite16_regfile
// Description : Scoreboard bench for lite16_regfile: directed scenarios plus
//               random traffic against an array-based reference model.
//               Honours LITE16_RF_BYPASS_EN (write-first vs read-first).
// Revision    : 1.0 - initial release
// ============================================================================

module tb_lite16_regfile;
  import lite16_pkg::*;

  localparam int NUM_REGS = LITE16_NUM_REGS;
  localparam int ZERO_REG = 1;
`ifdef LITE16_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst, we, re_a, re_b;
  reg_addr_t waddr, raddr_a, raddr_b;
  word_t     wdata, rdata_a, rdata_b;

  always #5 clk = ~clk;

  lite16_regfile #(
    .DATA_W   (LITE16_DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (LITE16_REG_ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re_a    (re_a),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .re_b    (re_b),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  typedef struct {
    word_t a;
    word_t b;
    string tag;
  } exp_t;

  exp_t  sb[$];
  int    checks   = 0;
  int    failures = 0;
  word_t m[NUM_REGS];
  word_t held_a, held_b;

  // Architectural view: what an enabled read returns this cycle.
  function automatic word_t model_read(input bit re, input reg_addr_t ra, input word_t held,
                                       input bit w, input reg_addr_t wa, input word_t wd);
    if (!re) return held;
    if (ZERO_REG != 0 && ra == 0) return '0;
    if (BYP && w && wa == ra) return wd;
    return m[ra];
  endfunction

  task automatic cyc(input string tag, input bit r, input bit w, input int wa, input word_t wd,
                     input bit ea, input int aa, input bit eb, input int ab);
    exp_t e;
    @(negedge clk);
    rst = r; we = w; waddr = reg_addr_t'(wa); wdata = wd;
    re_a = ea; raddr_a = reg_addr_t'(aa); re_b = eb; raddr_b = reg_addr_t'(ab);
    if (!r) begin
      foreach (m[i]) m[i] = '0;
      held_a = '0;
      held_b = '0;
    end else begin
      held_a = model_read(ea, reg_addr_t'(aa), held_a, w, reg_addr_t'(wa), wd);
      held_b = model_read(eb, reg_addr_t'(ab), held_b, w, reg_addr_t'(wa), wd);
      if (w && !(ZERO_REG != 0 && wa == 0)) m[wa] = wd;
    end
    e.a = held_a; e.b = held_b; e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 2;
        if (rdata_a !== e.a) begin
          failures++;
          $display("FAIL %s rdata_a got=%h expected=%h", e.tag, rdata_a, e.a);
        end
        if (rdata_b !== e.b) begin
          failures++;
          $display("FAIL %s rdata_b got=%h expected=%h", e.tag, rdata_b, e.b);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
    held_a = '0; held_b = '0;
    foreach (m[i]) m[i] = '0;

    // Reset with a write and reads pending, then sweep R1..R7.
    cyc("reset", 0, 1, 1, 16'hFFFF, 1, 1, 1, 2);
    for (int i = 1; i < NUM_REGS; i++) cyc("post_reset_rd", 1, 0, 0, 0, 1, i, 1, i);

    cyc("wr_r3", 1, 1, 3, 16'hAABB, 0, 0, 0, 0);
    cyc("rd_r3", 1, 0, 0, 0, 1, 3, 0, 0);
    cyc("hold_a", 1, 0, 0, 0, 0, 5, 0, 0);

    cyc("wr_r0", 1, 1, 0, 16'h1234, 0, 0, 0, 0);
    cyc("rd_r0", 1, 0, 0, 0, 1, 0, 1, 0);
    cyc("wr_rd_r0", 1, 1, 0, 16'h4321, 1, 0, 1, 0);

    cyc("wr_r5", 1, 1, 5, 16'h00AA, 0, 0, 0, 0);
    cyc("hazard_r5", 1, 1, 5, 16'h5500, 1, 5, 0, 0);
    cyc("after_hazard", 1, 0, 0, 0, 1, 5, 0, 0);

    cyc("wr_r2", 1, 1, 2, 16'hAA00, 0, 0, 0, 0);
    cyc("wr_r6", 1, 1, 6, 16'h00FF, 0, 0, 0, 0);
    cyc("dual_2_6", 1, 0, 0, 0, 1, 2, 1, 6);
    cyc("dual_6_6", 1, 0, 0, 0, 1, 6, 1, 6);

    cyc("wr_r4", 1, 1, 4, 16'hBEEF, 0, 0, 0, 0);
    cyc("reset_mid", 0, 1, 4, 16'h1111, 1, 4, 1, 4);
    cyc("rd_r4", 1, 0, 0, 0, 1, 4, 1, 4);
    cyc("rd_r6", 1, 0, 0, 0, 1, 6, 1, 2);

    for (int n = 0; n < 1500; n++) begin
      cyc("random", $urandom_range(63) != 0, $urandom_range(1) == 1, $urandom_range(NUM_REGS - 1),
          word_t'($urandom), $urandom_range(3) != 0, $urandom_range(NUM_REGS - 1),
          $urandom_range(3) != 0, $urandom_range(NUM_REGS - 1));
    end

    @(negedge clk);
    we = 1'b0; re_a = 1'b0; re_b = 1'b0; rst = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lite16_regfile

`default_nettype wire
